mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 90 +++++++++
 rtl/mc_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs, FSM states and mux encodings.
// sel_of() maps an instruction class to the datapath selects held through EXEC, MEM and WB.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] M1_RT = 2'b00;
  localparam logic [1:0] M1_RD = 2'b01;
  localparam logic [1:0] M1_RA = 2'b10;

  localparam logic [1:0] M3_ALU = 2'b00;
  localparam logic [1:0] M3_DM  = 2'b01;
  localparam logic [1:0] M3_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // One-hot class bit positions; an all-zero class vector means "unrecognised"
  localparam int CLS_W  = 10;
  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_ORI  = 2;
  localparam int C_LUI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_JR   = 9;

  typedef struct packed {
    logic [1:0] mux1;
    logic       mux2;
    logic [1:0] mux3;
    logic [1:0] aluop;
    logic [1:0] extop;
  } sel_t;

  function automatic sel_t sel_of(input logic [CLS_W-1:0] cls);
    sel_t s;
    s = '0;
    if (cls[C_ADDU] || cls[C_SUBU]) begin
      s.mux1  = M1_RD;
      s.mux3  = M3_ALU;
      s.aluop = cls[C_SUBU] ? ALU_SUB : ALU_ADD;
    end
    if (cls[C_ORI] || cls[C_LUI]) begin
      s.mux1  = M1_RT;
      s.mux2  = 1'b1;
      s.aluop = ALU_OR;
      s.extop = cls[C_LUI] ? EXT_LUI : EXT_ZERO;
    end
    if (cls[C_LW] || cls[C_SW]) begin
      s.mux2  = 1'b1;
      s.aluop = ALU_ADD;
      s.extop = EXT_SIGN;
    end
    if (cls[C_LW]) s.mux3 = M3_DM;
    if (cls[C_BEQ]) s.aluop = ALU_SUB;
    return s;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct of the IR to a one-hot class vector.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [CLS_W-1:0] cls
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    cls         = '0;
    cls[C_ADDU] = (op == OP_RTYPE) && (fn == FN_ADDU);
    cls[C_SUBU] = (op == OP_RTYPE) && (fn == FN_SUBU);
    cls[C_JR]   = (op == OP_RTYPE) && (fn == FN_JR);
    cls[C_ORI]  = (op == OP_ORI);
    cls[C_LUI]  = (op == OP_LUI);
    cls[C_LW]   = (op == OP_LW);
    cls[C_SW]   = (op == OP_SW);
    cls[C_BEQ]  = (op == OP_BEQ);
    cls[C_J]    = (op == OP_J);
    cls[C_JAL]  = (op == OP_JAL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB), 2..5 cycles per instruction, Moore outputs.
// Define MC_CTRL_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  output logic        IRWE,
  output logic        PCWE,
  output logic [1:0]  NPCOp,
  output logic [1:0]  MUX1,
  output logic        MUX2,
  output logic [1:0]  MUX3,
  output logic [1:0]  ALUOp,
  output logic [1:0]  EXTOp,
  output logic        GRFWE,
  output logic        DMWE,
  output logic        DMRE,
  output logic [31:0] retired
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CLS_W-1:0] cls;
  sel_t             sel;

  mc_decode u_decode (
    .instr (Instr),
    .cls   (cls)
  );

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (cls[C_ADDU] || cls[C_SUBU] || cls[C_ORI] || cls[C_LUI] ||
            cls[C_LW] || cls[C_SW] || cls[C_BEQ])
          state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls[C_LW] || cls[C_SW])
          state_nxt = ST_MEM;
        else if (cls[C_ADDU] || cls[C_SUBU] || cls[C_ORI] || cls[C_LUI])
          state_nxt = ST_WB;
      end
      ST_MEM:    state_nxt = cls[C_LW] ? ST_WB : ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  // Reset gates every output so an aborted instruction cannot leak a write strobe
  always_comb begin
    IRWE  = 1'b0;
    PCWE  = 1'b0;
    NPCOp = NPC_PC4;
    MUX1  = M1_RT;
    MUX2  = 1'b0;
    MUX3  = M3_ALU;
    ALUOp = ALU_ADD;
    EXTOp = EXT_ZERO;
    GRFWE = 1'b0;
    DMWE  = 1'b0;
    DMRE  = 1'b0;
    sel   = sel_of(cls);
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          IRWE  = 1'b1;
          PCWE  = 1'b1;
          NPCOp = NPC_PC4;
        end
        ST_DECODE: begin
          if (cls[C_J] || cls[C_JAL]) begin
            PCWE  = 1'b1;
            NPCOp = NPC_JUMP;
          end
          if (cls[C_JAL]) begin
            GRFWE = 1'b1;
            MUX1  = M1_RA;
            MUX3  = M3_PC4;
          end
          if (cls[C_JR]) begin
            PCWE  = 1'b1;
            NPCOp = NPC_RS;
          end
        end
        ST_EXEC, ST_MEM, ST_WB: begin
          MUX1  = sel.mux1;
          MUX2  = sel.mux2;
          MUX3  = sel.mux3;
          ALUOp = sel.aluop;
          EXTOp = sel.extop;
          if (state == ST_EXEC && cls[C_BEQ]) begin
            PCWE  = 1'b1;
            NPCOp = NPC_BEQ;
          end
          if (state == ST_MEM) begin
            DMRE = cls[C_LW];
            DMWE = cls[C_SW];
          end
          if (state == ST_WB) GRFWE = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        retire;

  assign retire = (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB) &&
                  (state_nxt == ST_FETCH);

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule
